rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
Shares the RTC multiplexed address/data bus (CS, AD, WR, RD, 8-bit bus, all strobes active-low) between two requesters: a write port (time/date setting from the keyboard path) and a read port (periodic register refresh for the display). It arbitrates, then sequences one complete address-phase plus data-phase bus cycle per grant with programmable phase timing. It sits between the control FSMs and the top-level RTC pins.

Parameters:
PHASE_CYC, 4, clock cycles per bus phase (setup/strobe/hold); legal range ≥1.
GAP_CYC, 2, idle cycles (all strobes high, bus released) after each transaction; ≥0.
IRQ_ADDR, 8'hF0, RTC register read when servicing IRQ (feature only).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_req  in  1  write request, held until wr_ack
wr_addr  in  8  RTC register address for write
wr_data  in  8  data to write
wr_ack  out  1  one-cycle pulse: write completed
rd_req  in  1  read request, held until rd_ack
rd_addr  in  8  RTC register address for read
rd_ack  out  1  one-cycle pulse: read completed, rd_data valid this cycle
rd_data  out  8  captured read data, held until next read
IRQ  in  1  RTC interrupt, active-low, asynchronous to clk
irq_valid  out  1  one-cycle pulse: IRQ register read done
irq_data  out  8  data read from IRQ_ADDR
busy  out  1  high from grant until end of GAP
CS, AD, WR, RD  out  1 each  RTC strobes, active-low
bus  inout  8  multiplexed address/data bus

Behaviour:
- Reset (async, takes effect immediately): CS=AD=WR=RD=1, bus high-Z, wr_ack=rd_ack=irq_valid=busy=0, rd_data=irq_data=8'h00, state IDLE, round-robin pointer favours write, IRQ pending cleared. Reset mid-transaction aborts it; no ack is issued.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP. Each A_*/D_* state lasts exactly PHASE_CYC cycles. GAP lasts GAP_CYC cycles and is skipped if GAP_CYC=0.
- IDLE: on a clock edge with any request, latch the granted address/data/type and enter A_SETUP; busy=1 from that cycle.
- Address phase (A_*): CS=0, bus drives the address; WR=0 and AD=0 only in A_STROBE, AD=1/WR=1 in A_SETUP and A_HOLD. RD=1 throughout.
- Data phase (D_*): CS=0, AD=1.
  - Write: bus drives data all three states; WR=0 only in D_STROBE.
  - Read: bus high-Z; RD=0 only in D_STROBE; bus sampled on the last cycle of D_STROBE.
- Ack/valid pulse in the last cycle of D_HOLD. Latency: request sampled at edge k, so ack is high in cycle k+6*PHASE_CYC.
- CS returns high in GAP. busy clears when re-entering IDLE.
- Arbitration when wr_req and rd_req are both high: round-robin, where the last-served port loses. After reset, write wins.
- A request deasserted before grant is ignored. A request deasserted mid-transaction does not stop it; the transaction completes and acks.
- Inputs are not re-sampled after grant.
- In IDLE, a request arriving in the same cycle as an ack of the same port is treated as a new request.

Optional Feature:
IRQ_SERVICE_EN
- Defined:
  - IRQ is synchronized with 2 flops; a falling edge sets an irq_pending flag.
  - Pending IRQ has highest priority at the next IDLE grant; it performs a read of IRQ_ADDR, pulses irq_valid with irq_data and clears pending. It does not affect the round-robin pointer.
  - An edge arriving during service re-sets pending.
- Undefined: IRQ is ignored, irq_valid=0, irq_data=8'h00.

Decomposition:
- Package rtc_bus_pkg: state encoding, transaction type constants (T_WR, T_RD, T_IRQ), default IRQ_ADDR, bus width 8.
- Natural sub-module rtc_bus_seq: phase counter plus strobe/bus generation for one transaction, with start/type/addr/data in and done/rdata out.
- The arbiter and IRQ logic stay in rtc_bus_arbiter.

Test Plan:
- Reset asserted mid-A_STROBE → all strobes 1 and bus Z in the same cycle; no ack after release.
- Single write: wr_addr=8'h21, wr_data=8'h59, PHASE_CYC=4 → WR low 4 cycles with bus=21 and AD=0; WR low 4 cycles with bus=59 and AD=1; wr_ack at cycle 24.
- Single read: rd_addr=8'h22, bus model returns 8'h09 during RD=0 → rd_ack at cycle 24 with rd_data=8'h09; bus not driven by DUT during D_*.
- wr_req and rd_req held together for 4 transactions → order W, R, W, R; each ack is one cycle; GAP of 2 cycles between transactions.
- With IRQ_SERVICE_EN: IRQ low pulse during a write, while rd_req is also pending → write completes, then IRQ read of F0 (irq_valid), then the read.
- Without IRQ_SERVICE_EN: IRQ toggling → no bus activity, irq_valid stays 0.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC bus arbiter
package rtc_bus_pkg;
    localparam int BUS_W = 8;
    localparam logic [BUS_W-1:0] IRQ_ADDR_DEF = 8'hF0;
    typedef enum logic [2:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_D_SETUP, S_D_STROBE, S_D_HOLD, S_GAP
    } state_t;
    typedef enum logic [1:0] {T_WR, T_RD, T_IRQ} xact_t;
endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// rtc_bus_arbiter_if: request/ack handshake between control FSMs and the bus arbiter
interface rtc_bus_arbiter_if;
    import rtc_bus_pkg::*;
    logic             wr_req, wr_ack, rd_req, rd_ack, irq_valid, busy;
    logic [BUS_W-1:0] wr_addr, wr_data, rd_addr, rd_data, irq_data;
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data, irq_valid, irq_data, busy
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data, irq_valid, irq_data, busy
    );
endinterface

// File: rtl/rtc_bus_seq.sv
// rtc_bus_seq: sequences one address+data cycle on the RTC multiplexed bus
module rtc_bus_seq import rtc_bus_pkg::*; #(
    parameter int PHASE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_read,
    input  logic [BUS_W-1:0] i_addr,
    input  logic [BUS_W-1:0] i_data,
    input  logic [BUS_W-1:0] i_bus,
    output logic             o_done,
    output logic             o_busy,
    output logic [BUS_W-1:0] o_rdata,
    output logic [BUS_W-1:0] o_bus,
    output logic             o_bus_oe,
    output logic             o_cs_n,
    output logic             o_ad_n,
    output logic             o_wr_n,
    output logic             o_rd_n
);
    localparam logic [15:0] P_LAST = 16'(PHASE_CYC - 1);
    localparam logic [15:0] G_LAST = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    state_t           r_state, w_next;
    logic [15:0]      r_cnt;
    logic             r_read, w_last, w_addr_ph, w_data_ph;
    logic [BUS_W-1:0] r_addr, r_data, r_rdata;
    // Next state: every phase lasts PHASE_CYC cycles, GAP lasts GAP_CYC or is skipped
    always_comb begin
        w_next = r_state;
        w_last = (r_state == S_GAP) ? (r_cnt == G_LAST) : (r_cnt == P_LAST);
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_A_SETUP;
            S_D_HOLD: if (w_last) w_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            S_GAP:    if (w_last) w_next = S_IDLE;
            default:  if (w_last) w_next = state_t'(r_state + 3'd1);
        endcase
    end
    // Strobes and bus drive decoded from the current phase
    always_comb begin
        w_addr_ph = r_state inside {S_A_SETUP, S_A_STROBE, S_A_HOLD};
        w_data_ph = r_state inside {S_D_SETUP, S_D_STROBE, S_D_HOLD};
        o_busy    = r_state != S_IDLE;
        o_cs_n    = !(w_addr_ph || w_data_ph);
        o_ad_n    = r_state != S_A_STROBE;
        o_wr_n    = !(r_state == S_A_STROBE || (r_state == S_D_STROBE && !r_read));
        o_rd_n    = !(r_state == S_D_STROBE && r_read);
        o_bus_oe  = w_addr_ph || (w_data_ph && !r_read);
        o_bus     = w_addr_ph ? r_addr : r_data;
        o_done    = r_state == S_D_HOLD && w_last;
        o_rdata   = r_rdata;
    end
    // State/counter register; transaction fields latched once at start, read data at end of strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 16'd1;
            if (r_state == S_IDLE && i_start) begin
                r_read <= i_read;
                r_addr <= i_addr;
                r_data <= i_data;
            end
            if (r_state == S_D_STROBE && r_read && w_last) r_rdata <= i_bus;
        end
    end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin arbiter for the RTC bus; IRQ_SERVICE_EN adds IRQ register reads
module rtc_bus_arbiter import rtc_bus_pkg::*; #(
    parameter int               PHASE_CYC = 4,
    parameter int               GAP_CYC   = 2,
    parameter logic [BUS_W-1:0] IRQ_ADDR  = IRQ_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    rtc_bus_arbiter_if.slave   req,
    input  logic               i_irq_n,
    output logic               o_cs_n,
    output logic               o_ad_n,
    output logic               o_wr_n,
    output logic               o_rd_n,
    inout  wire  [BUS_W-1:0]   io_bus
);
    xact_t            r_type, w_type;
    logic             r_last_wr, w_start, w_done, w_busy, w_pend, w_sel_wr, w_bus_oe;
    logic [BUS_W-1:0] r_rd_data, r_irq_data, w_addr, w_rdata, w_bus_out;
`ifdef IRQ_SERVICE_EN
    logic [2:0] r_irq_sync;
    logic       r_pend;
    // Synchronise IRQ, latch its falling edge as pending until the IRQ read is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_sync <= 3'b111;
            r_pend     <= 1'b0;
        end else begin
            r_irq_sync <= {r_irq_sync[1:0], i_irq_n};
            r_pend     <= (r_irq_sync[2] && !r_irq_sync[1]) || (r_pend && !w_start);
        end
    end
    assign w_pend = r_pend;
`else
    logic w_unused_irq;
    assign w_unused_irq = i_irq_n;
    assign w_pend       = 1'b0;
`endif
    // Grant: pending IRQ first, otherwise the port not served last wins a tie
    always_comb begin
        w_sel_wr = req.wr_req && (!req.rd_req || !r_last_wr);
        w_type   = w_pend ? T_IRQ : (w_sel_wr ? T_WR : T_RD);
        w_addr   = w_pend ? IRQ_ADDR : (w_sel_wr ? req.wr_addr : req.rd_addr);
        w_start  = !w_busy && (w_pend || req.wr_req || req.rd_req);
    end
    // Remember what was granted and keep the last read results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type     <= T_WR;
            r_last_wr  <= 1'b0;
            r_rd_data  <= '0;
            r_irq_data <= '0;
        end else begin
            if (w_start) r_type <= w_type;
            if (w_start && w_type != T_IRQ) r_last_wr <= w_type == T_WR;
            if (w_done && r_type == T_RD) r_rd_data <= w_rdata;
            if (w_done && r_type == T_IRQ) r_irq_data <= w_rdata;
        end
    end
    assign req.wr_ack    = w_done && r_type == T_WR;
    assign req.rd_ack    = w_done && r_type == T_RD;
    assign req.irq_valid = w_done && r_type == T_IRQ;
    assign req.rd_data   = req.rd_ack ? w_rdata : r_rd_data;
    assign req.irq_data  = req.irq_valid ? w_rdata : r_irq_data;
    assign req.busy      = w_busy;
    assign io_bus        = w_bus_oe ? w_bus_out : 'z;
    rtc_bus_seq #(.PHASE_CYC(PHASE_CYC), .GAP_CYC(GAP_CYC)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_read   (w_type != T_WR),
        .i_addr   (w_addr),
        .i_data   (req.wr_data),
        .i_bus    (io_bus),
        .o_done   (w_done),
        .o_busy   (w_busy),
        .o_rdata  (w_rdata),
        .o_bus    (w_bus_out),
        .o_bus_oe (w_bus_oe),
        .o_cs_n   (o_cs_n),
        .o_ad_n   (o_ad_n),
        .o_wr_n   (o_wr_n),
        .o_rd_n   (o_rd_n)
    );
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: randomized bench for rtc_bus_arbiter against a phase-arithmetic model
module tb_rtc_bus_arbiter;
    localparam int P = 4;
    localparam int G = 2;
    localparam int TX = 6 * P;
    localparam logic [7:0] IRQ_A = 8'hF0;
    logic clk = 0, rst_n = 0, irq_n = 1;
    logic cs_n, ad_n, wr_n, rd_n;
    wire [7:0] bus;
    logic [7:0] pins, rtc_addr = 8'h00;
    logic [7:0] mem [256];
    int n_chk = 0, n_err = 0, cyc = 0;
    bit m_active = 0, m_last_wr = 0, m_pend = 0;
    int m_start = 0, m_type = 0;
    logic [7:0] m_addr = 0, m_data = 0, m_rd_hold = 0, m_irq_hold = 0;
    rtc_bus_arbiter_if bif();
    rtc_bus_arbiter #(.PHASE_CYC(P), .GAP_CYC(G), .IRQ_ADDR(IRQ_A)) dut (
        .clk(clk), .rst_n(rst_n), .req(bif), .i_irq_n(irq_n),
        .o_cs_n(cs_n), .o_ad_n(ad_n), .o_wr_n(wr_n), .o_rd_n(rd_n), .io_bus(bus)
    );
    always #5 clk = ~clk;
    assign pins = {cs_n, ad_n, wr_n, rd_n, bif.busy, bif.wr_ack, bif.rd_ack, bif.irq_valid};
    always @(posedge ad_n) rtc_addr <= bus;
    assign bus = !rd_n ? mem[rtc_addr] : 8'bz;
    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, act, exp, cyc);
        end
    endtask
    task automatic model_edge();
        cyc++;
        if (m_active && cyc - 1 >= m_start + TX + G) m_active = 0;
        if (!m_active) begin
            if (m_pend) begin
                m_type = 2; m_addr = IRQ_A; m_pend = 0; m_active = 1;
            end else if (bif.wr_req && (!bif.rd_req || !m_last_wr)) begin
                m_type = 0; m_addr = bif.wr_addr; m_data = bif.wr_data; m_last_wr = 1; m_active = 1;
            end else if (bif.rd_req) begin
                m_type = 1; m_addr = bif.rd_addr; m_last_wr = 0; m_active = 1;
            end
            if (m_active) m_start = cyc;
        end
    endtask
    task automatic check_cycle();
        int o, ph;
        bit act, tx, done;
        o = cyc - m_start;
        act = m_active && o < TX + G;
        tx = act && o < TX;
        ph = o / P;
        done = tx && o == TX - 1;
        chk("pins", pins, {!tx, !(tx && ph == 1), !(tx && (ph == 1 || (ph == 4 && m_type == 0))),
            !(tx && ph == 4 && m_type != 0), act, done && m_type == 0, done && m_type == 1, done && m_type == 2});
        if (tx && (ph < 3 || m_type == 0)) chk("bus", bus, ph < 3 ? m_addr : m_data);
        if (done && m_type == 1) m_rd_hold = mem[m_addr];
        if (done && m_type == 2) m_irq_hold = mem[m_addr];
        chk("rd_data", bif.rd_data, m_rd_hold);
        chk("irq_data", bif.irq_data, m_irq_hold);
    endtask
    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask
    initial begin
        int lat, n_a, n_d, n;
        logic [7:0] order;
        bif.wr_req = 0; bif.rd_req = 0;
        bif.wr_addr = 0; bif.wr_data = 0; bif.rd_addr = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h22] = 8'h09;
        repeat (2) @(negedge clk);
        chk("rst_pins", pins, 8'hF0);
        chk("rst_rd_data", bif.rd_data, 8'h00);
        rst_n = 1;
        repeat (3) run_cycle();
        // single write 21/59
        bif.wr_addr = 8'h21; bif.wr_data = 8'h59; bif.wr_req = 1;
        n_a = 0; n_d = 0;
        for (lat = 1; lat <= 100; lat++) begin
            run_cycle();
            if (!wr_n && !ad_n && bus == 8'h21) n_a++;
            if (!wr_n && ad_n && bus == 8'h59) n_d++;
            if (bif.wr_ack) break;
        end
        bif.wr_req = 0;
        chk("wr_lat", 8'(lat), 8'd24);
        chk("wr_addr_strobe", 8'(n_a), 8'd4);
        chk("wr_data_strobe", 8'(n_d), 8'd4);
        repeat (4) run_cycle();
        // single read of 22 returning 09
        bif.rd_addr = 8'h22; bif.rd_req = 1;
        for (lat = 1; lat <= 100; lat++) begin
            run_cycle();
            if (bif.rd_ack) break;
        end
        chk("rd_ack_data", bif.rd_data, 8'h09);
        bif.rd_req = 0;
        chk("rd_lat", 8'(lat), 8'd24);
        repeat (4) run_cycle();
        // reset in the middle of the address strobe
        bif.wr_addr = 8'($urandom); bif.wr_req = 1;
        for (int i = 0; i < 60; i++) begin
            run_cycle();
            if (m_active && cyc - m_start == P + 1) break;
        end
        chk("pre_rst_ad", 8'(ad_n), 8'd0);
        rst_n = 0;
        #1;
        chk("mid_rst_pins", pins, 8'hF0);
        bif.wr_req = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        m_active = 0; m_last_wr = 0; m_pend = 0; m_rd_hold = 0; m_irq_hold = 0;
        chk("post_rst_rd_data", bif.rd_data, 8'h00);
        repeat (40) run_cycle();
        // both requests held: write, read, write, read
        bif.wr_req = 1; bif.rd_req = 1;
        bif.wr_addr = 8'($urandom); bif.wr_data = 8'($urandom); bif.rd_addr = 8'($urandom);
        n = 0; order = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            run_cycle();
            if (bif.wr_ack || bif.rd_ack) begin
                order = {order[6:0], bif.wr_ack};
                n++;
            end
        end
        chk("rr_order", order, 8'h0A);
        bif.wr_req = 0; bif.rd_req = 0;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run_cycle();
            if (bif.wr_ack) bif.wr_req = 0;
            else if (!bif.wr_req) bif.wr_req = $urandom_range(0, 3) == 0;
            else if ($urandom_range(0, 19) == 0) bif.wr_req = 0;
            if (bif.rd_ack) bif.rd_req = 0;
            else if (!bif.rd_req) bif.rd_req = $urandom_range(0, 3) == 0;
            else if ($urandom_range(0, 19) == 0) bif.rd_req = 0;
            if ($urandom_range(0, 3) == 0) begin
                bif.wr_addr = 8'($urandom); bif.wr_data = 8'($urandom); bif.rd_addr = 8'($urandom);
            end
`ifndef IRQ_SERVICE_EN
            if ($urandom_range(0, 3) == 0) irq_n = ~irq_n;
`endif
        end
        bif.wr_req = 0; bif.rd_req = 0; irq_n = 1;
        repeat (40) run_cycle();
`ifdef IRQ_SERVICE_EN
        // IRQ during a write with a read waiting: write, IRQ read, read
        bif.wr_addr = 8'h30; bif.wr_data = 8'($urandom); bif.wr_req = 1;
        repeat (3) run_cycle();
        bif.rd_addr = 8'h31; bif.rd_req = 1;
        irq_n = 0; m_pend = 1;
        repeat (2) run_cycle();
        irq_n = 1;
        n = 0; order = 0;
        for (int i = 0; i < 400 && n < 3; i++) begin
            run_cycle();
            if (bif.wr_ack || bif.rd_ack || bif.irq_valid) begin
                order = {order[5:0], bif.wr_ack ? 2'd1 : bif.irq_valid ? 2'd2 : 2'd3};
                n++;
            end
            if (bif.wr_ack) bif.wr_req = 0;
            if (bif.rd_ack) bif.rd_req = 0;
        end
        chk("irq_order", order, 8'h1B);
        bif.wr_req = 0; bif.rd_req = 0;
        repeat (40) run_cycle();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
